// File: rtl/seq_magcomp_if.sv
// ----------------------------------------------------------------------------
// seq_magcomp_if
//   Groups the handshake and operand/result signals of seq_magcomp.
//   master : requester side (drives start, signed_mode, a, b)
//   slave  : comparator side (drives busy, done, lt, gt, eq)
//   Signals:
//     start        request a compare; accepted only when busy==0
//     signed_mode  1 = two's-complement compare, 0 = unsigned
//     a, b         WIDTH-bit operands, sampled with start
//     busy         compare in progress
//     done         one-cycle pulse when lt/gt/eq are updated
//     lt, gt, eq   result of the last completed compare
//     min_out,     smaller / larger original operand
//     max_out      (present only when SEQ_MAGCOMP_MINMAX_EN is defined)
// ----------------------------------------------------------------------------
interface seq_magcomp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;
`ifdef SEQ_MAGCOMP_MINMAX_EN
    logic [WIDTH-1:0] min_out;
    logic [WIDTH-1:0] max_out;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, lt, gt, eq, min_out, max_out
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, lt, gt, eq, min_out, max_out
    );
`else
    modport master (
        output start, signed_mode, a, b,
        input  busy, done, lt, gt, eq
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, lt, gt, eq
    );
`endif
endinterface

// File: rtl/seq_magcomp.sv
// ----------------------------------------------------------------------------
// seq_magcomp
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands
//   MSB-first, CHUNK bits per clock, and stops at the first differing chunk.
//   Unsigned or two's-complement mode is chosen per operation.
//
//   Parameters:
//     WIDTH  operand width (>= 2)
//     CHUNK  bits examined per cycle; must divide WIDTH
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   seq_magcomp_if.slave (start/signed_mode/a/b in,
//           busy/done/lt/gt/eq out, plus min_out/max_out when enabled)
//
//   Build option:
//     SEQ_MAGCOMP_MINMAX_EN  adds min_out/max_out holding the smaller and
//                            larger original operand, updated with done.
// ----------------------------------------------------------------------------
module seq_magcomp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_magcomp_if.slave   bus
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic [CHUNK-1:0] chunk_a, chunk_b;

`ifdef SEQ_MAGCOMP_MINMAX_EN
    logic [WIDTH-1:0] orig_a_q, orig_a_d;
    logic [WIDTH-1:0] orig_b_q, orig_b_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
`endif

    // Operands shift left after each equal chunk, so the chunk under test is
    // always the top CHUNK bits; this replaces a variable part-select of
    // [WIDTH-1-i*CHUNK -: CHUNK] with fixed wiring.
    assign chunk_a = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b = b_q[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
`ifdef SEQ_MAGCOMP_MINMAX_EN
            orig_a_q <= '0;
            orig_b_q <= '0;
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
`ifdef SEQ_MAGCOMP_MINMAX_EN
            orig_a_q <= orig_a_d;
            orig_b_q <= orig_b_d;
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
`ifdef SEQ_MAGCOMP_MINMAX_EN
        orig_a_d = orig_a_q;
        orig_b_d = orig_b_q;
        min_d    = min_q;
        max_d    = max_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Flipping the sign bits maps two's-complement ordering
                    // onto unsigned ordering, so every chunk compare is unsigned.
                    a_d     = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                    b_d     = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                    idx_d   = '0;
                    state_d = CMP;
`ifdef SEQ_MAGCOMP_MINMAX_EN
                    orig_a_d = bus.a;
                    orig_b_d = bus.b;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            CMP: begin
                if (chunk_a != chunk_b) begin
                    lt_d    = (chunk_a < chunk_b);
                    gt_d    = (chunk_a > chunk_b);
                    eq_d    = 1'b0;
                    state_d = DONE;
`ifdef SEQ_MAGCOMP_MINMAX_EN
                    min_d = (chunk_a < chunk_b) ? orig_a_q : orig_b_q;
                    max_d = (chunk_a < chunk_b) ? orig_b_q : orig_a_q;
`endif
                end else if (idx_q == IW'(NCH - 1)) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
`ifdef SEQ_MAGCOMP_MINMAX_EN
                    min_d = orig_a_q;
                    max_d = orig_a_q;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                    a_d   = a_q << CHUNK;
                    b_d   = b_q << CHUNK;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == CMP);
    assign bus.done = (state_q == DONE);
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
`ifdef SEQ_MAGCOMP_MINMAX_EN
    assign bus.min_out = min_q;
    assign bus.max_out = max_q;
`endif

endmodule

// File: tb/tb_seq_magcomp.sv
// ----------------------------------------------------------------------------
// tb_seq_magcomp
//   Self-checking bench for seq_magcomp (WIDTH=16, CHUNK=4). Stimulus pushes
//   expected results (from an arithmetic reference) into a scoreboard queue;
//   an independent monitor pops and compares on every done pulse.
//   Honours SEQ_MAGCOMP_MINMAX_EN for the min_out/max_out checks.
// ----------------------------------------------------------------------------
module tb_seq_magcomp;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         lt;
        logic         gt;
        logic         eq;
        int unsigned  exp_cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    exp_t        sb[$];

    seq_magcomp_if #(.WIDTH(W)) bus ();

    seq_magcomp #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: ordering from plain signed/unsigned arithmetic; latency is
    // the position of the first nonzero chunk of a^b counted from the MSB.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int unsigned now);
        exp_t        e;
        logic [W-1:0] x;
        int unsigned  k;
        e.a  = a;
        e.b  = b;
        e.lt = s ? ($signed(a) < $signed(b)) : (a < b);
        e.gt = s ? ($signed(a) > $signed(b)) : (a > b);
        e.eq = (a == b);
        x = a ^ b;
        k = NCH;
        for (int i = 0; i < NCH; i++) begin
            if (((x >> (W - (i + 1) * CH)) & 16'h000F) != 16'h0000) begin
                k = i + 1;
                break;
            end
        end
        e.exp_cyc = now + 1 + k;
        return e;
    endfunction

    // Waits (bounded) for busy==0 with start held at its current level and
    // operands scrambled, then presents one compare on a negedge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic is, input bit keep);
        int unsigned guard;
        guard = 0;
        while (bus.busy && guard < 40) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.signed_mode = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            chk("busy_timeout", 32'(bus.busy), 32'd0);
        end
        bus.start       = 1'b1;
        bus.a           = ia;
        bus.b           = ib;
        bus.signed_mode = is;
        sb.push_back(model(ia, ib, is, cyc));
        @(negedge clk);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        if (!keep) bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
    endtask

    // Monitor: every done pulse must match the oldest expectation, in
    // result and in timing; an overdue expectation is a failure too.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected no pending compare (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("lt", 32'(bus.lt), 32'(e.lt));
                    chk("gt", 32'(bus.gt), 32'(e.gt));
                    chk("eq", 32'(bus.eq), 32'(e.eq));
                    chk("done_cycle", cyc, e.exp_cyc);
`ifdef SEQ_MAGCOMP_MINMAX_EN
                    chk("min_out", 32'(bus.min_out), 32'(e.lt ? e.a : (e.gt ? e.b : e.a)));
                    chk("max_out", 32'(bus.max_out), 32'(e.lt ? e.b : e.a));
`endif
                end
            end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done by cycle %0d expected done at %0d", cyc, e.exp_cyc);
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        int unsigned  r, guard;
        bit           kp;

        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_lt",   32'(bus.lt),   32'd0);
        chk("rst_gt",   32'(bus.gt),   32'd0);
        chk("rst_eq",   32'(bus.eq),   32'd0);
`ifdef SEQ_MAGCOMP_MINMAX_EN
        chk("rst_min", 32'(bus.min_out), 32'd0);
        chk("rst_max", 32'(bus.max_out), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        issue(16'h0007, 16'h0007, 1'b0, 1'b0);   // equal, full latency
        issue(16'h9000, 16'h8FFF, 1'b0, 1'b0);   // early exit, gt
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0);   // signed -1 < 1
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);   // unsigned gt
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b0);   // signed min vs max
        issue(16'h0004, 16'h0006, 1'b0, 1'b1);   // back-to-back chain
        issue(16'h0009, 16'h0008, 1'b0, 1'b1);
        issue(16'h000A, 16'h000A, 1'b0, 1'b0);

        // Reset in the middle of a full-length compare.
        guard = 0;
        while (bus.busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_lt",   32'(bus.lt),   32'd0);
        chk("midrst_gt",   32'(bus.gt),   32'd0);
        chk("midrst_eq",   32'(bus.eq),   32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);   // monitor flags any done here

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            r  = $urandom_range(3, 0);
            if (r == 0)      rb = ra;
            else if (r == 1) rb = ra ^ (16'h0001 << $urandom_range(W - 1, 0));
            else             rb = W'($urandom);
            kp = (n != 199) && ($urandom_range(1, 0) == 1);
            issue(ra, rb, 1'($urandom), kp);
            if (!kp) repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        bus.start = 1'b0;

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            chk("drain", sb.size(), 32'd0);
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
